// File: rtl/cp0_if.sv
// ---------------------------------------------------------------------------
// cp0_if : bus between the multi-cycle control FSM (master) and the
//          Coprocessor-0 register block (slave).
//
// Signals
//   mtc0, wcau, exc, wsta, wepc, inta, cause_sel : FSM strobes into CP0
//   reg_addr [4:0]  : CP0 register number (Inst[15:11])
//   wdata   [31:0]  : GPR rt data for mtc0
//   pc_in   [31:0]  : PC of interrupted / faulting instruction
//   rdata   [31:0]  : mfc0 read data (combinational on reg_addr)
//   status  [31:0]  : Status register
//   epc     [31:0]  : EPC register
//   vector  [31:0]  : exception handler entry address
//   int_req         : registered interrupt request to the FSM
// ---------------------------------------------------------------------------
interface cp0_if;
    logic        mtc0;
    logic        wcau;
    logic        exc;
    logic        wsta;
    logic        wepc;
    logic        inta;
    logic        cause_sel;
    logic [4:0]  reg_addr;
    logic [31:0] wdata;
    logic [31:0] pc_in;
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] vector;
    logic        int_req;

    modport master (
        output mtc0, wcau, exc, wsta, wepc, inta, cause_sel, reg_addr, wdata, pc_in,
        input  rdata, status, epc, vector, int_req
    );

    modport slave (
        input  mtc0, wcau, exc, wsta, wepc, inta, cause_sel, reg_addr, wdata, pc_in,
        output rdata, status, epc, vector, int_req
    );
endinterface

// File: rtl/cp0_regs.sv
// ---------------------------------------------------------------------------
// cp0_regs : Coprocessor-0 register block (Status, Cause, EPC) for the
//            multi-cycle MIPS core.
//
// Ports
//   clk           : system clock
//   reset         : asynchronous, active-high reset
//   irq_in_i      : level interrupt lines, asynchronous to clk
//   irq_ack_o     : one-cycle acknowledge of the serviced line
//   irq_ack_id_o  : index of the acknowledged line (valid with irq_ack_o)
//   bus           : cp0_if.slave (FSM strobes, mfc0 read, Status/EPC/vector,
//                   int_req)
//
// Optional feature: define CP0_TIMER_EN to add Count (reg 9) and Compare
// (reg 11) with a sticky timer interrupt on Cause.IP[7].
// ---------------------------------------------------------------------------
module cp0_regs #(
    parameter int          NUM_IRQ      = 5,
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0008,
    parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in_i,
    output logic               irq_ack_o,
    output logic [2:0]         irq_ack_id_o,
    cp0_if.slave               bus
);
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    logic [NUM_IRQ-1:0] sync1_q, sync2_q;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;
    logic        int_req_q, int_req_d;
    logic        irq_ack_q, irq_ack_d;
    logic [2:0]  irq_ack_id_q, irq_ack_id_d;
    logic [7:0]  ip_s, pend_s;
    logic        ip7_s, hit_s;
    logic [2:0]  hit_id_s;
    logic [31:0] status_s, cause_s;
    logic        wr_status_s, wr_cause_s, wr_epc_s;

    assign wr_status_s = bus.mtc0 && (bus.reg_addr == REG_STATUS);
    assign wr_cause_s  = bus.mtc0 && (bus.reg_addr == REG_CAUSE);
    assign wr_epc_s    = bus.mtc0 && (bus.reg_addr == REG_EPC);

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        ip7_q, ip7_d;
    logic        wr_count_s, wr_compare_s;

    assign wr_count_s   = bus.mtc0 && (bus.reg_addr == REG_COUNT);
    assign wr_compare_s = bus.mtc0 && (bus.reg_addr == REG_COMPARE);

    // Timer next state: a Count write overrides both the increment and a match.
    always_comb begin
        count_d   = wr_count_s ? bus.wdata : (count_q + 32'd1);
        compare_d = wr_compare_s ? bus.wdata : compare_q;
        if (wr_compare_s) begin
            ip7_d = 1'b0;
        end else if ((count_q == compare_q) && !wr_count_s) begin
            ip7_d = 1'b1;
        end else begin
            ip7_d = ip7_q;
        end
    end

    // Timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'h0000_0000;
            compare_q <= 32'h0000_0000;
            ip7_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ip7_q     <= ip7_d;
        end
    end

    assign ip7_s = ip7_q;
`else
    assign ip7_s = 1'b0;
`endif

    // Assemble Cause.IP: software bits, synchronised lines, timer bit.
    always_comb begin
        ip_s                = 8'h00;
        ip_s[1:0]           = ip_sw_q;
        ip_s[NUM_IRQ+1:2]   = sync2_q;
        ip_s[7]             = ip7_s;
    end

    assign pend_s = ip_s & im_q;

    // Highest-index pending enabled external line (ascending scan, last hit wins).
    always_comb begin
        hit_s    = 1'b0;
        hit_id_s = 3'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pend_s[i+2]) begin
                hit_s    = 1'b1;
                hit_id_s = 3'(i);
            end
        end
    end

    // Register next state; later assignments carry the higher priority.
    always_comb begin
        im_d       = im_q;
        ie_d       = ie_q;
        exl_d      = exl_q;
        ip_sw_d    = ip_sw_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (wr_status_s) begin
            im_d  = bus.wdata[15:8];
            exl_d = bus.wdata[1];
            ie_d  = bus.wdata[0];
        end else begin
            im_d = im_q;
        end
        if (wr_cause_s) begin
            ip_sw_d = bus.wdata[9:8];
        end else begin
            ip_sw_d = ip_sw_q;
        end
        if (wr_epc_s) begin
            epc_d = bus.wdata;
        end else begin
            epc_d = epc_q;
        end
        if (bus.wepc) begin
            epc_d = bus.pc_in;
        end else begin
            epc_d = epc_d;
        end
        if (bus.wcau) begin
            exc_code_d = bus.cause_sel ? 5'd0 : (bus.inta ? 5'd8 : 5'd10);
        end else begin
            exc_code_d = exc_code_q;
        end
        if (bus.exc) begin
            exl_d = 1'b1;
        end else if (bus.wsta) begin
            exl_d = 1'b0;
        end else begin
            exl_d = exl_d;
        end
        int_req_d    = (|pend_s) & ie_q & ~exl_q;
        irq_ack_d    = bus.exc && bus.cause_sel && hit_s;
        irq_ack_id_d = (bus.exc && bus.cause_sel) ? hit_id_s : 3'd0;
    end

    // State registers, interrupt synchronisers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            im_q         <= STATUS_RESET[15:8];
            exl_q        <= STATUS_RESET[1];
            ie_q         <= STATUS_RESET[0];
            ip_sw_q      <= 2'b00;
            exc_code_q   <= 5'd0;
            epc_q        <= 32'h0000_0000;
            int_req_q    <= 1'b0;
            irq_ack_q    <= 1'b0;
            irq_ack_id_q <= 3'd0;
        end else begin
            sync1_q      <= irq_in_i;
            sync2_q      <= sync1_q;
            im_q         <= im_d;
            exl_q        <= exl_d;
            ie_q         <= ie_d;
            ip_sw_q      <= ip_sw_d;
            exc_code_q   <= exc_code_d;
            epc_q        <= epc_d;
            int_req_q    <= int_req_d;
            irq_ack_q    <= irq_ack_d;
            irq_ack_id_q <= irq_ack_id_d;
        end
    end

    assign status_s = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
    assign cause_s  = {16'h0000, ip_s, 1'b0, exc_code_q, 2'b00};

    // mfc0 read mux; unmapped registers read zero.
    always_comb begin
        bus.rdata = 32'h0000_0000;
        case (bus.reg_addr)
            REG_STATUS:  bus.rdata = status_s;
            REG_CAUSE:   bus.rdata = cause_s;
            REG_EPC:     bus.rdata = epc_q;
`ifdef CP0_TIMER_EN
            REG_COUNT:   bus.rdata = count_q;
            REG_COMPARE: bus.rdata = compare_q;
`endif
            default:     bus.rdata = 32'h0000_0000;
        endcase
    end

    assign bus.status   = status_s;
    assign bus.epc      = epc_q;
    assign bus.vector   = VECTOR_ADDR;
    assign bus.int_req  = int_req_q;
    assign irq_ack_o    = irq_ack_q;
    assign irq_ack_id_o = irq_ack_id_q;
endmodule

// File: tb/tb_cp0_regs.sv
// ---------------------------------------------------------------------------
// tb_cp0_regs : directed self-checking bench for cp0_regs.
// ---------------------------------------------------------------------------
module tb_cp0_regs;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] irq_in;
    logic       irq_ack;
    logic [2:0] irq_ack_id;
    int         passes = 0;
    int         fails  = 0;
    int         total  = 0;

    cp0_if bus();

    cp0_regs #(.NUM_IRQ(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in_i     (irq_in),
        .irq_ack_o    (irq_ack),
        .irq_ack_id_o (irq_ack_id),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.mtc0 = 1'b0; bus.wcau = 1'b0; bus.exc = 1'b0; bus.wsta = 1'b0;
        bus.wepc = 1'b0; bus.inta = 1'b0; bus.cause_sel = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus.reg_addr = addr;
        bus.wdata    = data;
        bus.mtc0     = 1'b1;
        tick();
        bus.mtc0     = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.reg_addr = addr;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        reset = 1'b1; irq_in = 5'b00000; clr();
        bus.reg_addr = 5'd0; bus.wdata = 32'h0; bus.pc_in = 32'h0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_status", bus.status, 32'h0000_0000);
        chk("rst_epc", bus.epc, 32'h0000_0000);
        chk("rst_int_req", {31'b0, bus.int_req}, 32'd0);
        chk("rst_irq_ack", {31'b0, irq_ack}, 32'd0);
        chk("vector", bus.vector, 32'h0000_0008);
        rd("rst_cause", 5'd13, 32'h0000_0000);

        // Hardware interrupt on line 0
        wr(5'd12, 32'h0000_0401);
        chk("status_wr", bus.status, 32'h0000_0401);
        rd("status_rd", 5'd12, 32'h0000_0401);
        irq_in = 5'b00001;
        tick(); tick();
        chk("int_req_early", {31'b0, bus.int_req}, 32'd0);
        rd("cause_ip2", 5'd13, 32'h0000_0400);
        tick();
        chk("int_req_3cyc", {31'b0, bus.int_req}, 32'd1);
        bus.exc = 1'b1; bus.wcau = 1'b1; bus.wsta = 1'b1; bus.wepc = 1'b1;
        bus.cause_sel = 1'b1; bus.pc_in = 32'h0000_0040;
        tick(); clr();
        chk("hw_epc", bus.epc, 32'h0000_0040);
        chk("hw_exl", bus.status, 32'h0000_0403);
        chk("hw_ack", {31'b0, irq_ack}, 32'd1);
        chk("hw_ack_id", {29'b0, irq_ack_id}, 32'd0);
        rd("hw_cause", 5'd13, 32'h0000_0400);
        tick();
        chk("hw_ack_pulse", {31'b0, irq_ack}, 32'd0);
        chk("hw_int_req_off", {31'b0, bus.int_req}, 32'd0);

        // Masking by EXL, then eret
        irq_in = 5'b00011;
        wr(5'd12, 32'h0000_0C03);
        repeat (3) tick();
        chk("exl_mask", {31'b0, bus.int_req}, 32'd0);
        rd("cause_ip23", 5'd13, 32'h0000_0C00);
        bus.wsta = 1'b1;
        tick(); clr();
        chk("eret_status", bus.status, 32'h0000_0C01);
        tick();
        chk("eret_int_req", {31'b0, bus.int_req}, 32'd1);

        // Syscall
        bus.exc = 1'b1; bus.wcau = 1'b1; bus.wepc = 1'b1; bus.inta = 1'b1;
        bus.pc_in = 32'h0000_0100;
        tick(); clr();
        chk("sys_epc", bus.epc, 32'h0000_0100);
        rd("sys_cause", 5'd13, 32'h0000_0C20);
        chk("sys_noack", {31'b0, irq_ack}, 32'd0);
        tick();
        chk("sys_noack2", {31'b0, irq_ack}, 32'd0);
        bus.wsta = 1'b1; tick(); clr();

        // Priority: lines 0 and 2 pending and enabled
        irq_in = 5'b00101;
        wr(5'd12, 32'h0000_1401);
        tick(); tick();
        bus.exc = 1'b1; bus.wcau = 1'b1; bus.wsta = 1'b1; bus.cause_sel = 1'b1;
        tick(); clr();
        chk("prio_ack", {31'b0, irq_ack}, 32'd1);
        chk("prio_ack_id", {29'b0, irq_ack_id}, 32'd2);
        tick();
        chk("prio_ack_pulse", {31'b0, irq_ack}, 32'd0);

        // Lost race: nothing pending at entry
        bus.wsta = 1'b1; tick(); clr();
        irq_in = 5'b00000;
        tick(); tick();
        bus.exc = 1'b1; bus.wcau = 1'b1; bus.cause_sel = 1'b1;
        tick(); clr();
        chk("lost_race_noack", {31'b0, irq_ack}, 32'd0);

        // Register map details and write conflicts
        wr(5'd5, 32'hDEAD_BEEF);
        rd("unmapped", 5'd5, 32'h0000_0000);
        wr(5'd13, 32'hFFFF_FFFF);
        rd("cause_sw_only", 5'd13, 32'h0000_0300);
        bus.reg_addr = 5'd14; bus.wdata = 32'h0000_1234; bus.mtc0 = 1'b1;
        bus.wepc = 1'b1; bus.pc_in = 32'h0000_0200;
        tick(); clr();
        chk("wepc_beats_mtc0", bus.epc, 32'h0000_0200);
        wr(5'd14, 32'hCAFE_0000);
        chk("epc_mtc0", bus.epc, 32'hCAFE_0000);
        bus.reg_addr = 5'd12; bus.wdata = 32'h0000_FF02; bus.mtc0 = 1'b1; bus.wsta = 1'b1;
        tick(); clr();
        chk("eret_vs_mtc0", bus.status, 32'h0000_FF00);
        bus.reg_addr = 5'd12; bus.wdata = 32'h0000_FF01; bus.mtc0 = 1'b1; bus.exc = 1'b1;
        tick(); clr();
        chk("exc_vs_mtc0", bus.status, 32'h0000_FF03);

`ifdef CP0_TIMER_EN
        wr(5'd9, 32'h0000_0000);
        wr(5'd11, 32'h0000_000A);
        rd("count_run", 5'd9, 32'h0000_0001);
        repeat (9) tick();
        rd("timer_not_yet", 5'd13, 32'h0000_0300);
        tick();
        rd("timer_ip7", 5'd13, 32'h0000_8300);
        wr(5'd11, 32'h0000_0032);
        rd("timer_clear", 5'd13, 32'h0000_0300);
        wr(5'd9, 32'hFFFF_FFFF);
        rd("count_max", 5'd9, 32'hFFFF_FFFF);
        tick();
        rd("count_wrap", 5'd9, 32'h0000_0000);
`else
        rd("count_absent", 5'd9, 32'h0000_0000);
        rd("compare_absent", 5'd11, 32'h0000_0000);
        rd("ip7_absent", 5'd13, 32'h0000_0300);
`endif

        // Asynchronous reset in the middle of an acknowledge
        irq_in = 5'b00001;
        tick(); tick();
        bus.exc = 1'b1; bus.cause_sel = 1'b1;
        tick(); clr();
        chk("pre_reset_ack", {31'b0, irq_ack}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_status", bus.status, 32'h0000_0000);
        chk("arst_epc", bus.epc, 32'h0000_0000);
        chk("arst_int_req", {31'b0, bus.int_req}, 32'd0);
        chk("arst_irq_ack", {31'b0, irq_ack}, 32'd0);
        chk("arst_ack_id", {29'b0, irq_ack_id}, 32'd0);
        rd("arst_cause", 5'd13, 32'h0000_0000);
        tick();
        reset = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 register block for the multi-cycle MIPS core; it is the responder to the control FSM's CP0 strobes (mtc0, wcau, exc, wsta, wepc, inta).
- Holds Status, Cause and EPC.
- Synchronises external interrupt lines, raises the registered INT request to the FSM, and acknowledges the serviced line back to the interrupt source.
- Supplies EPC and the exception vector to the PC mux, and read data for mfc0.

Parameters:
- NUM_IRQ, 5, number of external interrupt lines (1..5), mapped to Cause.IP[NUM_IRQ+1:2].
- VECTOR_ADDR, 32'h0000_0008, exception handler entry address.
- STATUS_RESET, 32'h0000_0000, Status value after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- irq_in  in  NUM_IRQ  level interrupt lines, asynchronous to clk.
- mtc0  in  1  write wdata to CP0 register reg_addr.
- wcau  in  1  load Cause.ExcCode.
- exc  in  1  exception entry: set Status.EXL.
- wsta  in  1  Status stack update (entry when exc=1, eret when exc=0).
- wepc  in  1  load EPC from pc_in.
- inta  in  1  software-exception marker; when high with exc, ExcCode=8 (Syscall).
- cause_sel  in  1  1 = hardware interrupt entry, ExcCode=0.
- reg_addr  in  5  CP0 register number (Inst[15:11]).
- wdata  in  32  GPR rt data for mtc0.
- pc_in  in  32  PC of interrupted/faulting instruction.
- rdata  out  32  combinational read of reg_addr.
- status  out  32  Status register.
- epc  out  32  EPC register.
- vector  out  32  constant VECTOR_ADDR.
- int_req  out  1  registered interrupt request to the control FSM.
- irq_ack  out  1  one-cycle acknowledge pulse.
- irq_ack_id  out  3  index of acknowledged line; valid while irq_ack=1.

Behaviour:
- Reset: Status=STATUS_RESET, Cause=0, EPC=0, sync flops=0, int_req=0, irq_ack=0, irq_ack_id=0. Reset mid-handshake drops irq_ack immediately.
- Register map:
  - reg 12 Status: [15:8] IM, [1] EXL, [0] IE; other bits read 0.
  - reg 13 Cause: [15:8] IP, [6:2] ExcCode; other bits read 0.
  - reg 14 EPC.
  - Unmapped registers read 0; writes to them are ignored.
- Interrupt sync: irq_in passes through 2 flops per line (2-cycle latency). Cause.IP[NUM_IRQ+1:2] follows the synced level each cycle (not sticky). IP[1:0] are software bits, writable only via mtc0 to Cause.
- int_req: registered each cycle as |(IP & IM) & IE & ~EXL. It appears 1 cycle after a qualifying IP/Status change, i.e. 3 cycles after an irq_in edge.
- Exception entry, in the cycle exc=1:
  - EXL<=1.
  - if wepc, EPC<=pc_in.
  - if wcau, ExcCode <= cause_sel ? 0 : (inta ? 8 : 10).
  - if cause_sel=1, capture the highest-index pending enabled line (IP&IM). The next cycle drives irq_ack=1 for exactly 1 cycle with irq_ack_id = that index minus 2.
  - If no enabled line is pending at entry (lost race), no ack is issued.
- eret: wsta=1 with exc=0 sets EXL<=0. int_req may re-assert on the following cycle.
- mtc0:
  - Status writes bits [15:8],[1:0].
  - Cause writes IP[1:0] only.
  - EPC writes all 32 bits.
- Simultaneous events:
  - exc beats mtc0 on the EXL bit.
  - wepc beats an mtc0 to EPC.
  - A write to Status in the same cycle as eret: eret wins on EXL, mtc0 wins on the other bits.
- rdata is combinational from the current register values. The write-cycle value is visible the cycle after the write.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined:
  - Adds Count (reg 9), which increments every clk and is writable by mtc0.
  - Adds Compare (reg 11).
  - When Count==Compare, sticky IP[7] sets; an mtc0 to Compare clears it.
  - Count wraps 32'hFFFF_FFFF -> 0.
  - If the Count write and the match occur in the same cycle, the write wins and there is no set.
- Undefined: regs 9/11 read 0, and IP[7] reads 0.

Test Plan:
- Reset: assert reset mid-cycle -> status=0, epc=0, int_req=0, irq_ack=0 immediately (asynchronous).
- Hardware interrupt:
  - Stimulus: mtc0 Status=32'h0000_0401 (IM[2]=1, IE=1), then raise irq_in[0].
  - Response: int_req=1 3 cycles later.
  - Then pulse exc+wcau+wsta+wepc+cause_sel with pc_in=32'h0000_0040. Response: EPC=0x40, ExcCode=0, EXL=1, int_req=0 next cycle, irq_ack=1 with irq_ack_id=0 for 1 cycle.
- Syscall: exc+wcau+wepc+inta, cause_sel=0, pc_in=32'h100 -> ExcCode=8, EPC=0x100, no irq_ack.
- Masking and eret:
  - With EXL=1 and irq_in[1] high, int_req stays 0.
  - Pulse wsta with exc=0 -> EXL=0, int_req=1 one cycle later if IM[3]=1, IE=1.
- Priority: irq_in=5'b00101 both enabled, hardware entry -> irq_ack_id=2.
- CP0_TIMER_EN:
  - mtc0 Count=0, Compare=10 -> IP[7]=1 after 10 increments.
  - mtc0 Compare=50 -> IP[7]=0.
  - Count=32'hFFFF_FFFF wraps to 0.
